// File: rtl/controle_rodadas.sv
// controle_rodadas: round-sequencing controller for the memory game.
// Moore FSM that walks the play/round counters, strobes the button register,
// reads back the datapath comparison and reports win, error or timeout.
// Optional macro CONTROLE_TIMEOUT_EN builds the player-timeout counter; without
// it ESPERA waits forever and the FIM_TIMEOUT code decodes as an unused code.
module controle_rodadas #(
   parameter int TIMEOUT = 5000
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       fim_jogada,
   input  logic       fim_rodada,
   output logic       zera_jogada,
   output logic       conta_jogada,
   output logic       zera_rodada,
   output logic       conta_rodada,
   output logic       registra,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] estado
);

   typedef enum logic [3:0] {
      INICIAL       = 4'h0,
      PREPARA       = 4'h1,
      INICIO_RODADA = 4'h2,
      ESPERA        = 4'h3,
      REGISTRA      = 4'h4,
      COMPARA       = 4'h5,
      PROX_JOGADA   = 4'h6,
      PROX_RODADA   = 4'h7,
      FIM_ACERTO    = 4'hA,
      FIM_TIMEOUT   = 4'hD,
      FIM_ERRO      = 4'hE
   } estado_t;

   estado_t atual, proximo;
   logic    fim_tempo;

   // A counter of $clog2(TIMEOUT) bits needs at least two cycles of budget
   if (TIMEOUT < 2) begin : g_timeout_invalido
      $error("controle_rodadas: TIMEOUT must be at least 2");
   end

`ifdef CONTROLE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT - 1);

   logic [CW-1:0] contagem;

   // Count cycles spent in ESPERA; cleared on every exit so it never wraps
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         contagem <= '0;
      else if (atual == ESPERA && proximo == ESPERA)
         contagem <= contagem + CW'(1);
      else
         contagem <= '0;
   end

   // A press on the last allowed cycle beats the timeout
   assign fim_tempo = (atual == ESPERA) && (contagem == LIMITE) && !jogada;
`else
   assign fim_tempo = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         atual <= INICIAL;
      else
         atual <= proximo;
   end

   // Next-state and Moore output decode
   always_comb begin
      proximo      = atual;
      zera_jogada  = 1'b0;
      conta_jogada = 1'b0;
      zera_rodada  = 1'b0;
      conta_rodada = 1'b0;
      registra     = 1'b0;
      pronto       = 1'b0;
      acertou      = 1'b0;
      errou        = 1'b0;
      timeout      = 1'b0;
      case (atual)
         INICIAL: if (iniciar) proximo = PREPARA;
         PREPARA: begin
            zera_jogada = 1'b1;
            zera_rodada = 1'b1;
            proximo     = INICIO_RODADA;
         end
         INICIO_RODADA: begin
            zera_jogada = 1'b1;
            proximo     = ESPERA;
         end
         ESPERA: begin
            if (jogada)         proximo = REGISTRA;
            else if (fim_tempo) proximo = FIM_TIMEOUT;
         end
         REGISTRA: begin
            registra = 1'b1;
            proximo  = COMPARA;
         end
         COMPARA: begin
            if (!igual)                      proximo = FIM_ERRO;
            else if (fim_jogada && fim_rodada) proximo = FIM_ACERTO;
            else if (fim_jogada)             proximo = PROX_RODADA;
            else                             proximo = PROX_JOGADA;
         end
         PROX_JOGADA: begin
            conta_jogada = 1'b1;
            proximo      = ESPERA;
         end
         PROX_RODADA: begin
            conta_rodada = 1'b1;
            proximo      = INICIO_RODADA;
         end
         FIM_ACERTO: begin
            pronto  = 1'b1;
            acertou = 1'b1;
            if (iniciar) proximo = PREPARA;
         end
`ifdef CONTROLE_TIMEOUT_EN
         FIM_TIMEOUT: begin
            pronto  = 1'b1;
            timeout = 1'b1;
            if (iniciar) proximo = PREPARA;
         end
`endif
         FIM_ERRO: begin
            pronto = 1'b1;
            errou  = 1'b1;
            if (iniciar) proximo = PREPARA;
         end
         default: proximo = INICIAL;
      endcase
   end

   assign estado = atual;

endmodule

// File: doc/controle_rodadas.md
# controle_rodadas

Round-sequencing controller for the memory game. Each round the player must repeat one more step of the stored sequence, and this block drives that loop. It steps the play counter (`contador_jogadas`, M = round index) and the round counter. It strobes the button register and reads back the datapath comparison. It reports game success, error or player timeout. It sits between the game's top-level start input and the datapath counters/comparators, one instance per game.

## Interface
- `TIMEOUT`, default 5000: cycles allowed in ESPERA before timeout. Legal range ≥ 2. Internal counter width is $clog2(TIMEOUT).
- `clock`  in  1  system clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `iniciar`  in  1  start request; sampled in INICIAL and in the three final states
- `jogada`  in  1  one-cycle pulse, player pressed a button (already edge-detected)
- `igual`  in  1  datapath: registered button equals memory word; valid in COMPARA
- `fim_jogada`  in  1  play counter equals current round index
- `fim_rodada`  in  1  round counter at last round
- `zera_jogada`  out  1  clear play counter
- `conta_jogada`  out  1  increment play counter
- `zera_rodada`  out  1  clear round counter
- `conta_rodada`  out  1  increment round counter
- `registra`  out  1  load button register
- `pronto`  out  1  game finished (any outcome)
- `acertou`  out  1  game won
- `errou`  out  1  wrong button
- `timeout`  out  1  player too slow
- `estado`  out  4  current state code (debug/display)

## Operation
- Moore FSM. The state register is reset asynchronously. All outputs decode combinationally from the state only.
- States and codes:
  - INICIAL 0x0: no strobes. `iniciar` → PREPARA.
  - PREPARA 0x1: `zera_jogada` = 1, `zera_rodada` = 1. → INICIO_RODADA.
  - INICIO_RODADA 0x2: `zera_jogada` = 1. → ESPERA.
  - ESPERA 0x3: waits for a play. `jogada` → REGISTRA. Timeout reached → FIM_TIMEOUT.
  - REGISTRA 0x4: `registra` = 1. → COMPARA.
  - COMPARA 0x5: evaluated in this priority order:
    - `!igual` → FIM_ERRO
    - `fim_jogada && fim_rodada` → FIM_ACERTO
    - `fim_jogada` → PROX_RODADA
    - otherwise → PROX_JOGADA
  - PROX_JOGADA 0x6: `conta_jogada` = 1. → ESPERA.
  - PROX_RODADA 0x7: `conta_rodada` = 1. → INICIO_RODADA.
  - FIM_ACERTO 0xA: `pronto` = 1, `acertou` = 1.
  - FIM_TIMEOUT 0xD: `pronto` = 1, `timeout` = 1.
  - FIM_ERRO 0xE: `pronto` = 1, `errou` = 1.
- In all three final states, `iniciar` → PREPARA. Status flags drop as soon as the state is left.
- Unused codes → INICIAL on the next edge, with all outputs 0.
- Timeout counter:
  - Held at 0 in every state except ESPERA; increments by 1 per cycle in ESPERA.
  - Timeout is reached when count == TIMEOUT-1 and `jogada` = 0.
  - A simultaneous `jogada` wins.
  - The counter does not wrap (the FSM leaves ESPERA first).
- Ignored inputs:
  - `jogada` outside ESPERA is ignored and not buffered.
  - `iniciar` outside INICIAL and the final states is ignored (no restart mid-game).

## Timing
- Reset (`rst_n` low, any time including mid-game): `estado` = 0x0 and every output 0 immediately. The timeout counter is 0.
- `iniciar` high at edge k → PREPARA during cycle k+1, INICIO_RODADA at k+2, ESPERA at k+3.
- `jogada` sampled in ESPERA at edge t:
  - `registra` high in cycle t+1.
  - COMPARA in t+2.
  - Outcome state in t+3, i.e. the `conta_*` strobe or final flags appear three cycles after the press.
- Each strobe is exactly one cycle wide.
- Full timeout: ESPERA is entered at edge e; with no press, FIM_TIMEOUT is entered at edge e+TIMEOUT.

## Configuration
- `CONTROLE_TIMEOUT_EN` defined: timeout counter and the ESPERA→FIM_TIMEOUT transition are built as above.
- Undefined:
  - No counter logic.
  - `timeout` tied to 0; FIM_TIMEOUT is unreachable, and its code behaves as an unused code.
  - ESPERA waits indefinitely for `jogada`.

## Test plan
- Reset mid-game: drive to COMPARA, pull `rst_n` low between edges → `estado` = 0 and all outputs 0 without a clock edge. Releasing reset keeps INICIAL until `iniciar`.
- Two-round win:
  - Drive `iniciar`, then press with `igual` = 1 throughout.
  - Round 1: `fim_jogada` = 1 on the first press → PROX_RODADA, `conta_rodada` for one cycle.
  - Round 2: first press `fim_jogada` = 0 → `conta_jogada` for one cycle. Second press `fim_jogada` = 1, `fim_rodada` = 1 → `estado` = 0xA, `pronto` = `acertou` = 1 three cycles after the press.
- Error: first press with `igual` = 0 → `estado` = 0xE, `errou` = `pronto` = 1 three cycles after the press, with no `conta_*` pulse. Then `iniciar` → `estado` = 0x1 next cycle and flags 0.
- Timeout (`TIMEOUT` = 8, macro defined):
  - No press → `estado` = 0xD and `timeout` = 1 exactly 8 edges after entering ESPERA.
  - Repeat with a press on the 8th edge → REGISTRA and no timeout.
- Ignored inputs: `jogada` pulses during PREPARA/REGISTRA/COMPARA, and `iniciar` during ESPERA → state sequence and strobes unchanged.
- Macro undefined: hold ESPERA for 10000 cycles → remains 0x3, `timeout` stays 0.
